// File: rtl/log_group_sequencer_if.sv
// Handshake bundle between the mel accumulator, log_group_sequencer and the log unit.
// Optional clamp_cnt exists only when LOG_SEQ_CLAMP_EN is defined.
interface log_group_sequencer_if #(
    parameter int I_BW   = 30,
    parameter int N_ELEM = 64
);
    localparam int IW = $clog2(N_ELEM);

    logic [I_BW*N_ELEM-1:0] di_data;
    logic [6:0]             di_group_num;
    logic                   di_en;
    logic                   di_rdy;
    logic [I_BW-1:0]        lg_data;
    logic [IW-1:0]          lg_idx;
    logic [6:0]             lg_num;
    logic                   lg_en;
    logic                   lg_do_en;
    logic [IW-1:0]          lg_out_idx;
    logic                   group_done;
    logic [6:0]             done_num;
    logic                   frame_done;
    logic                   err;
`ifdef LOG_SEQ_CLAMP_EN
    logic [15:0]            clamp_cnt;

    modport slave (
        input  di_data, di_group_num, di_en, lg_do_en, lg_out_idx,
        output di_rdy, lg_data, lg_idx, lg_num, lg_en, group_done, done_num, frame_done, err, clamp_cnt
    );
    modport master (
        output di_data, di_group_num, di_en, lg_do_en, lg_out_idx,
        input  di_rdy, lg_data, lg_idx, lg_num, lg_en, group_done, done_num, frame_done, err, clamp_cnt
    );
`else
    modport slave (
        input  di_data, di_group_num, di_en, lg_do_en, lg_out_idx,
        output di_rdy, lg_data, lg_idx, lg_num, lg_en, group_done, done_num, frame_done, err
    );
    modport master (
        output di_data, di_group_num, di_en, lg_do_en, lg_out_idx,
        input  di_rdy, lg_data, lg_idx, lg_num, lg_en, group_done, done_num, frame_done, err
    );
`endif
endinterface

// File: rtl/log_group_sequencer.sv
// Issues one packed group of energies to the single-issue log unit, one element per cycle, and checks in-order returns.
// LOG_SEQ_CLAMP_EN: replaces non-positive elements with 1 before issue and counts replacements in clamp_cnt.
module log_group_sequencer #(
    parameter int I_BW    = 30,
    parameter int N_ELEM  = 64,
    parameter int N_GROUP = 89,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    log_group_sequencer_if.slave sif
);
    localparam int IW = $clog2(N_ELEM);
    localparam int GW = 7;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);
    localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUP - 1);
    localparam logic [SW-1:0] SIL_MAX  = SW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                 r_state;
    logic [I_BW*N_ELEM-1:0] r_data;
    logic [IW-1:0]          r_iss;
    logic [IW-1:0]          r_ret;
    logic [SW-1:0]          r_sil;
    logic                   r_di_rdy;
    logic [I_BW-1:0]        r_lg_data;
    logic [IW-1:0]          r_lg_idx;
    logic [GW-1:0]          r_lg_num;
    logic                   r_lg_en;
    logic                   r_group_done;
    logic [GW-1:0]          r_done_num;
    logic                   r_frame_done;
    logic                   r_err;

    logic [I_BW-1:0] w_head;
    logic [I_BW-1:0] w_issue_val;
    logic            w_clamp_hit;
    logic            w_accept;
    logic            w_issue;
    logic            w_last_ret;

    // Element 0 goes out straight from the input bus on acceptance; the rest shift out of r_data.
    always_comb begin
        w_head = (r_state == S_IDLE) ? sif.di_data[I_BW-1:0] : r_data[I_BW-1:0];
`ifdef LOG_SEQ_CLAMP_EN
        w_clamp_hit = ($signed(w_head) <= 0);
`else
        w_clamp_hit = 1'b0;
`endif
        w_issue_val = w_clamp_hit ? I_BW'(1) : w_head;
    end

    assign w_accept   = (r_state == S_IDLE) && sif.di_en && r_di_rdy;
    assign w_issue    = w_accept || (r_state == S_ISSUE);
    assign w_last_ret = sif.lg_do_en && (r_ret == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_iss        <= '0;
            r_ret        <= '0;
            r_sil        <= '0;
            r_di_rdy     <= 1'b1;
            r_lg_data    <= '0;
            r_lg_idx     <= '0;
            r_lg_num     <= '0;
            r_lg_en      <= 1'b0;
            r_group_done <= 1'b0;
            r_done_num   <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_group_done <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_lg_en <= 1'b0;
                    if (sif.lg_do_en) r_err <= 1'b1;
                    if (w_accept) begin
                        r_data    <= sif.di_data >> I_BW;
                        r_lg_num  <= sif.di_group_num;
                        r_lg_en   <= 1'b1;
                        r_lg_data <= w_issue_val;
                        r_lg_idx  <= '0;
                        r_iss     <= IW'(1);
                        r_ret     <= '0;
                        r_sil     <= '0;
                        r_di_rdy  <= 1'b0;
                        if (sif.di_group_num > LAST_GRP) r_err <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_lg_en   <= 1'b1;
                    r_lg_data <= w_issue_val;
                    r_lg_idx  <= r_iss;
                    r_data    <= r_data >> I_BW;
                    r_iss     <= r_iss + IW'(1);
                    if (r_iss == LAST_IDX) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_lg_en <= 1'b0;
                    if (w_last_ret) begin
                        r_group_done <= 1'b1;
                        r_done_num   <= r_lg_num;
                        r_frame_done <= (r_lg_num == LAST_GRP);
                        r_di_rdy     <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (!sif.lg_do_en) begin
                        if (r_sil >= SIL_MAX) begin
                            r_err    <= 1'b1;
                            r_di_rdy <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_sil <= r_sil + SW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Return index is checked against the running count; the count advances even on a mismatch.
            if ((r_state != S_IDLE) && sif.lg_do_en) begin
                r_ret <= r_ret + IW'(1);
                r_sil <= '0;
                if (sif.lg_out_idx != r_ret) r_err <= 1'b1;
            end
        end
    end

`ifdef LOG_SEQ_CLAMP_EN
    logic [15:0] r_clamp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clamp_cnt <= '0;
        end else if (w_issue && w_clamp_hit && (r_clamp_cnt != 16'hFFFF)) begin
            r_clamp_cnt <= r_clamp_cnt + 16'd1;
        end
    end

    assign sif.clamp_cnt = r_clamp_cnt;
`endif

    assign sif.di_rdy     = r_di_rdy;
    assign sif.lg_data    = r_lg_data;
    assign sif.lg_idx     = r_lg_idx;
    assign sif.lg_num     = r_lg_num;
    assign sif.lg_en      = r_lg_en;
    assign sif.group_done = r_group_done;
    assign sif.done_num   = r_done_num;
    assign sif.frame_done = r_frame_done;
    assign sif.err        = r_err;
endmodule

// File: tb/tb_log_group_sequencer.sv
// Scoreboard bench for log_group_sequencer: a latency-1 log unit model returns issued indices,
// and a monitor checks every issue and every group_done against queued expectations.
module tb_log_group_sequencer;
    localparam int I_BW    = 30;
    localparam int N_ELEM  = 64;
    localparam int N_GROUP = 89;
    localparam int TIMEOUT = 255;
    localparam int LAT     = 1;

    typedef struct { logic [I_BW-1:0] data; int idx; int num; } iss_t;
    typedef struct { int num; bit frame; } done_t;
    typedef struct { int idx; int due; } ret_t;

    logic clk;
    logic rst;
    log_group_sequencer_if #(.I_BW(I_BW), .N_ELEM(N_ELEM)) sif();

    log_group_sequencer #(.I_BW(I_BW), .N_ELEM(N_ELEM), .N_GROUP(N_GROUP), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    iss_t  exp_iss[$];
    done_t exp_done[$];
    int    runs[$];
    int    exp_clamp = 0;
    int    mode = 0;          // 0 normal, 1 swap returns 10/11, 2 drop final return
    int    stray_req = 0;
    int    stray_served = 0;
    int    last_ret_cyc = -10;
    int    ret62_cyc = -1;
    int    n_done_seen = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [I_BW-1:0] model_elem(input logic [I_BW-1:0] e);
`ifdef LOG_SEQ_CLAMP_EN
        if ($signed(e) <= 0) return I_BW'(1);
`endif
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Log unit model: every issue comes back LAT cycles later, reordered or dropped per mode.
    ret_t pend[$];
    ret_t rt;
    int   oi;
    int   pos = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            pend.delete();
            pos          = 0;
            ret62_cyc    = -1;
            sif.lg_do_en   = 1'b0;
            sif.lg_out_idx = '0;
        end else begin
            if (sif.lg_en) begin
                oi = int'(sif.lg_idx);
                if (mode == 1 && oi == 10) oi = 11;
                else if (mode == 1 && oi == 11) oi = 10;
                if (!(mode == 2 && int'(sif.lg_idx) == N_ELEM - 1))
                    pend.push_back('{oi, cyc + LAT});
            end
            sif.lg_do_en   = 1'b0;
            sif.lg_out_idx = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                rt = pend.pop_front();
                sif.lg_do_en   = 1'b1;
                sif.lg_out_idx = 6'(rt.idx);
                if (pos == N_ELEM - 2) ret62_cyc = cyc;
                if (pos == N_ELEM - 1) begin
                    last_ret_cyc = cyc;
                    pos = 0;
                end else begin
                    pos++;
                end
            end else if (stray_req != stray_served) begin
                sif.lg_do_en = 1'b1;
                stray_served++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an issue or a completion.
    iss_t  mi;
    done_t md;
    int    run = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            run = 0;
        end else begin
            if (sif.lg_en) begin
                run++;
                if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", longint'(sif.lg_en), 0);
                end else begin
                    mi = exp_iss.pop_front();
                    chk("lg_data", longint'(sif.lg_data), longint'(mi.data));
                    chk("lg_idx", longint'(sif.lg_idx), longint'(mi.idx));
                    chk("lg_num", longint'(sif.lg_num), longint'(mi.num));
                end
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (sif.group_done) begin
                n_done_seen++;
                if (exp_done.size() == 0) begin
                    chk("unexpected_group_done", longint'(sif.group_done), 0);
                end else begin
                    md = exp_done.pop_front();
                    chk("done_num", longint'(sif.done_num), longint'(md.num));
                    chk("frame_done", longint'(sif.frame_done), longint'(md.frame));
                    chk("done_latency", longint'(cyc), longint'(last_ret_cyc + 1));
                end
            end else if (sif.frame_done) begin
                chk("frame_without_group", longint'(sif.frame_done), 0);
            end
        end
    end

    task automatic send_group(input int grp, input logic [I_BW*N_ELEM-1:0] d, input bit want_done);
        iss_t it;
        logic [I_BW-1:0] e;
        int n;
        for (int k = 0; k < N_ELEM; k++) begin
            e = d[k*I_BW +: I_BW];
            it.data = model_elem(e);
            it.idx  = k;
            it.num  = grp;
            exp_iss.push_back(it);
            if ($signed(e) <= 0) exp_clamp++;
        end
        if (want_done) exp_done.push_back('{grp, grp == N_GROUP - 1});
        @(negedge clk);
        sif.di_data      = d;
        sif.di_group_num = 7'(grp);
        sif.di_en        = 1'b1;
        n = 0;
        while (!sif.di_rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!sif.di_rdy) chk("accept_wait", longint'(sif.di_rdy), 1);
        @(posedge clk);
        #1;
        sif.di_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_iss.size() != 0 || exp_done.size() != 0 || !sif.di_rdy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_issues_left"}, exp_iss.size(), 0);
        chk({tag, "_dones_left"}, exp_done.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_iss.delete();
        exp_done.delete();
        runs.delete();
        exp_clamp = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [I_BW*N_ELEM-1:0] d;
        int c0;
        int nd0;
        sif.di_data      = '0;
        sif.di_group_num = '0;
        sif.di_en        = 1'b0;
        sif.lg_do_en     = 1'b0;
        sif.lg_out_idx   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_di_rdy", longint'(sif.di_rdy), 1);
        chk("rst_lg_en", longint'(sif.lg_en), 0);
        chk("rst_err", longint'(sif.err), 0);
        chk("rst_group_done", longint'(sif.group_done), 0);
        chk("rst_frame_done", longint'(sif.frame_done), 0);
        chk("rst_done_num", longint'(sif.done_num), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_di_rdy", longint'(sif.di_rdy), 1);
        chk("idle_lg_en", longint'(sif.lg_en), 0);

        // Single group 5 with elements k+1: one unbroken burst of N_ELEM issues.
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'(k + 1);
        runs.delete();
        send_group(5, d, 1'b1);
        wait_idle("single");
        chk("single_runs", runs.size(), 1);
        if (runs.size() > 0) chk("single_burst_len", runs[0], N_ELEM);
        chk("single_err", longint'(sif.err), 0);

        // Back-to-back 87 then 88; only 88 closes the frame.
        runs.delete();
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
        send_group(87, d, 1'b1);
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
        send_group(88, d, 1'b1);
        wait_idle("b2b");
        chk("b2b_runs", runs.size(), 2);
        foreach (runs[i]) chk("b2b_burst_len", runs[i], N_ELEM);

        // Random groups and random signed data.
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
            send_group(int'($urandom_range(0, N_GROUP - 1)), d, 1'b1);
        end
        wait_idle("random");
        chk("random_err", longint'(sif.err), 0);

        // Out-of-range group number: processed normally, err raised.
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
        send_group(100, d, 1'b1);
        wait_idle("badgrp");
        chk("badgrp_err", longint'(sif.err), 1);

        // Timeout: final return never arrives.
        do_reset();
        chk("post_rst_err", longint'(sif.err), 0);
        mode = 2;
        nd0 = n_done_seen;
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'(k + 3);
        send_group(20, d, 1'b0);
        c0 = 0;
        while (ret62_cyc < 0 && c0 < 500) begin
            @(negedge clk);
            c0++;
        end
        chk("timeout_ret62_seen", longint'(ret62_cyc >= 0), 1);
        c0 = ret62_cyc;
        while (cyc < c0 + TIMEOUT) @(negedge clk);
        chk("timeout_err_early", longint'(sif.err), 0);
        chk("timeout_rdy_early", longint'(sif.di_rdy), 0);
        while (cyc < c0 + TIMEOUT + 3) @(negedge clk);
        chk("timeout_err", longint'(sif.err), 1);
        chk("timeout_di_rdy", longint'(sif.di_rdy), 1);
        chk("timeout_no_done", n_done_seen, nd0);
        chk("timeout_issues_left", exp_iss.size(), 0);
        mode = 0;

        // Swapped returns 10/11: err sticks, group still completes.
        do_reset();
        mode = 1;
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
        send_group(7, d, 1'b1);
        wait_idle("swap");
        chk("swap_err", longint'(sif.err), 1);
        repeat (5) @(negedge clk);
        chk("swap_err_sticky", longint'(sif.err), 1);
        mode = 0;

        // Reset mid-group discards it; the next group runs cleanly.
        do_reset();
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
        send_group(3, d, 1'b1);
        repeat (20) @(negedge clk);
        do_reset();
        chk("midrst_lg_en", longint'(sif.lg_en), 0);
        chk("midrst_di_rdy", longint'(sif.di_rdy), 1);
        chk("midrst_err", longint'(sif.err), 0);
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'($urandom);
        send_group(4, d, 1'b1);
        wait_idle("after_midrst");

        // Stray return while idle.
        @(negedge clk);
        stray_req++;
        repeat (3) @(negedge clk);
        chk("stray_err", longint'(sif.err), 1);

        // Non-positive elements: clamped only when the clamp build option is present.
        do_reset();
        for (int k = 0; k < N_ELEM; k++) d[k*I_BW +: I_BW] = I_BW'(k + 1);
        d[0 +: I_BW]      = I_BW'(0);
        d[I_BW +: I_BW]   = I_BW'(-7);
        d[2*I_BW +: I_BW] = I_BW'(100);
        send_group(9, d, 1'b1);
        wait_idle("clamp");
`ifdef LOG_SEQ_CLAMP_EN
        chk("clamp_cnt", longint'(sif.clamp_cnt), exp_clamp);
`endif
        chk("clamp_err", longint'(sif.err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
